icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/icache.sv | 101 ++++++++++
 tb/tb_icache.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// +------------------------------------------------------------------+
// | cpu_types_pkg                                                    |
// | Shared CPU word type and instruction-cache address field layout. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ITAG_W = 26;
    localparam int IIDX_W = 4;
    localparam int IBYT_W = 2;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [IBYT_W-1:0] bytoff;
    } icachef_t;

endpackage

`default_nettype wire

// File: rtl/icache.sv
// +------------------------------------------------------------------+
// | icache                                                           |
// | Direct-mapped, one-word-per-frame, read-only instruction cache.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module icache
    import cpu_types_pkg::*;
#(
    parameter int ISETS = 16
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload
);

    localparam int IDX_W = $clog2(ISETS);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [29:0]      maddr_q, maddr_d;
    logic [ISETS-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [ISETS];
    word_t            data_q [ISETS];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_midx;
    logic [TAG_W-1:0] w_mtag;
    logic             w_hit;
    logic             w_fill;
    logic             w_unused_offset;

    assign w_idx  = imemaddr[IDX_W+1:2];
    assign w_tag  = imemaddr[31:IDX_W+2];
    assign w_midx = maddr_q[IDX_W-1:0];
    assign w_mtag = maddr_q[29:IDX_W];

    // Byte offset never affects lookup: every frame holds one whole word.
    assign w_unused_offset = ^imemaddr[1:0];

    assign w_hit  = imemREN && (state_q == IDLE) && valid_q[w_idx] && (tag_q[w_idx] == w_tag);
    assign w_fill = (state_q == FETCH) && !iwait;

    assign ihit     = w_hit;
    assign imemload = w_hit ? data_q[w_idx] : '0;
    assign iREN     = (state_q == FETCH);
    assign iaddr    = (state_q == FETCH) ? {maddr_q, 2'b00} : '0;

    always_comb begin
        state_d = state_q;
        maddr_d = maddr_q;
        if (state_q == IDLE) begin
            if (imemREN && !w_hit) begin
                state_d = FETCH;
                maddr_d = imemaddr[31:2];
            end
        end else begin
            // Fill runs to completion regardless of what the datapath does now.
            if (!iwait) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            maddr_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            maddr_q <= maddr_d;
            if (w_fill) begin
                valid_q[w_midx] <= 1'b1;
            end
        end
    end

    // Tag/data need no reset; a fill pending at reset is dropped here.
    always_ff @(posedge CLK) begin
        if (nRST && w_fill) begin
            tag_q[w_midx]  <= w_mtag;
            data_q[w_midx] <= iload;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// +------------------------------------------------------------------+
// | tb_icache                                                        |
// | Directed self-checking bench for the instruction cache.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int checks = 0;
    int errors = 0;

    icache #(.ISETS(16)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    always #5 CLK = ~CLK;

    // Full miss: request cycle, `waits` busy cycles, data cycle, then the hit.
    task automatic run_miss(input logic [31:0] a, input logic [31:0] d, input int waits, input string nm);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = a; iwait = 1'b1; iload = '0;
        #1;
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0 || imemload !== 32'h0) begin
            errors++;
            $display("FAIL %s_miss_start ihit=%b iREN=%b iaddr=%h load=%h want 0 0 0 0", nm, ihit, iREN, iaddr, imemload);
        end
        for (int i = 0; i < waits; i++) begin
            @(negedge CLK);
            iwait = 1'b1;
            #1;
            checks++;
            if (iREN !== 1'b1 || iaddr !== wa || ihit !== 1'b0) begin
                errors++;
                $display("FAIL %s_wait%0d iREN=%b iaddr=%h ihit=%b want 1 %h 0", nm, i, iREN, iaddr, ihit, wa);
            end
        end
        @(negedge CLK);
        iwait = 1'b0; iload = d;
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== wa || ihit !== 1'b0) begin
            errors++;
            $display("FAIL %s_fill iREN=%b iaddr=%h ihit=%b want 1 %h 0", nm, iREN, iaddr, ihit, wa);
        end
        @(negedge CLK);
        iwait = 1'b1; iload = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== d || iREN !== 1'b0) begin
            errors++;
            $display("FAIL %s_after ihit=%b load=%h iREN=%b want 1 %h 0", nm, ihit, imemload, iREN, d);
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b1; iload = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        checks++;
        if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0 || iaddr !== 32'h0) begin
            errors++;
            $display("FAIL reset ihit=%b load=%h iREN=%b iaddr=%h want all 0", ihit, imemload, iREN, iaddr);
        end
        imemREN = 1'b0;
        nRST = 1'b1;
    endtask

    task automatic test_cold_miss();
        run_miss(32'h0000_0000, 32'h3C01_0001, 3, "cold");
    endtask

    task automatic test_hit();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            imemREN = 1'b1; imemaddr = 32'h0;
            #1;
            checks++;
            if (ihit !== 1'b1 || imemload !== 32'h3C01_0001 || iREN !== 1'b0) begin
                errors++;
                $display("FAIL hit%0d ihit=%b load=%h iREN=%b want 1 3c010001 0", i, ihit, imemload, iREN);
            end
        end
    endtask

    task automatic test_conflict();
        run_miss(32'h0000_0040, 32'h2002_0002, 1, "conf40");
        @(negedge CLK);
        imemaddr = 32'h40;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'h2002_0002) begin
            errors++;
            $display("FAIL conflict_hit40 ihit=%b load=%h want 1 20020002", ihit, imemload);
        end
        run_miss(32'h0000_0000, 32'h3C01_0001, 2, "conf00");
        @(negedge CLK);
        imemaddr = 32'h40;
        #1;
        checks++;
        if (ihit !== 1'b0 || imemload !== 32'h0) begin
            errors++;
            $display("FAIL conflict_evicted40 ihit=%b load=%h want 0 0", ihit, imemload);
        end
        imemREN = 1'b0;
    endtask

    task automatic test_offset();
        logic [31:0] a;
        run_miss(32'h0000_0004, 32'h8C03_0004, 0, "off");
        for (int o = 5; o <= 7; o++) begin
            @(negedge CLK);
            a = o;
            imemREN = 1'b1; imemaddr = a;
            #1;
            checks++;
            if (ihit !== 1'b1 || imemload !== 32'h8C03_0004) begin
                errors++;
                $display("FAIL offset_%0d ihit=%b load=%h want 1 8c030004", o, ihit, imemload);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h8; iwait = 1'b1;
        @(negedge CLK);
        #1;
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h8) begin
            errors++;
            $display("FAIL rstmid_fetch iREN=%b iaddr=%h want 1 00000008", iREN, iaddr);
        end
        nRST = 1'b0;
        @(negedge CLK);
        #1;
        checks++;
        if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after iREN=%b iaddr=%h ihit=%b want 0 0 0", iREN, iaddr, ihit);
        end
        nRST = 1'b1;
        imemREN = 1'b0;
        run_miss(32'h0000_0000, 32'h3C01_0001, 1, "rst00");
        run_miss(32'h0000_0008, 32'h1111_1111, 0, "rst08");
    endtask

    task automatic test_request_drop();
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h10; iwait = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            imemREN = 1'b0; imemaddr = 32'h44;
            #1;
            checks++;
            if (iREN !== 1'b1 || iaddr !== 32'h10 || ihit !== 1'b0 || imemload !== 32'h0) begin
                errors++;
                $display("FAIL drop_hold%0d iREN=%b iaddr=%h ihit=%b load=%h want 1 10 0 0", i, iREN, iaddr, ihit, imemload);
            end
        end
        @(negedge CLK);
        iwait = 1'b0; iload = 32'hAABB_CCDD;
        #1;
        checks++;
        if (iREN !== 1'b1 || ihit !== 1'b0) begin
            errors++;
            $display("FAIL drop_fill iREN=%b ihit=%b want 1 0", iREN, ihit);
        end
        @(negedge CLK);
        iwait = 1'b1; iload = '0;
        #1;
        checks++;
        if (iREN !== 1'b0 || ihit !== 1'b0 || imemload !== 32'h0) begin
            errors++;
            $display("FAIL drop_idle iREN=%b ihit=%b load=%h want 0 0 0", iREN, ihit, imemload);
        end
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h10;
        #1;
        checks++;
        if (ihit !== 1'b1 || imemload !== 32'hAABB_CCDD) begin
            errors++;
            $display("FAIL drop_written ihit=%b load=%h want 1 aabbccdd", ihit, imemload);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        addrs = '{32'h0, 32'h8, 32'h10};
        datas = '{32'h3C01_0001, 32'h1111_1111, 32'hAABB_CCDD};
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            imemREN = 1'b1; imemaddr = addrs[i];
            #1;
            checks++;
            if (ihit !== 1'b1 || imemload !== datas[i] || iREN !== 1'b0) begin
                errors++;
                $display("FAIL b2b_%0d ihit=%b load=%h iREN=%b want 1 %h 0", i, ihit, imemload, iREN, datas[i]);
            end
        end
        // Reset before the drop test cleared index 1, so 0x4 must miss.
        @(negedge CLK);
        imemaddr = 32'h4;
        #1;
        checks++;
        if (ihit !== 1'b0 || imemload !== 32'h0) begin
            errors++;
            $display("FAIL b2b_cleared4 ihit=%b load=%h want 0 0", ihit, imemload);
        end
        imemREN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_offset();
        test_reset_mid_fetch();
        test_request_drop();
        test_back_to_back();
        repeat (2) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
